// File: rtl/fp32_div_sched.sv
// rtl/fp32_div_sched.sv - two-requester round-robin FP32 divider sharing one multicycle mantissa divider
module div24 (
    input  logic [22:0] ma_i,
    input  logic [22:0] mb_i,
    output logic [24:0] quo_o
);
    logic [47:0] num;
    logic [47:0] den;

    assign num   = {1'b1, ma_i, 24'd0};
    assign den   = {24'd0, 1'b1, mb_i};
    assign quo_o = 25'(num / den);
endmodule

module fp32_div_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_id,
    output logic [3:0]            res_flags
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam logic [3:0] CNT_INIT = 4'(DIV_LAT - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic                  id_q, last_grant_q;
    logic [3:0]            cnt_q;
    logic                  res_valid_q, res_id_q;
    logic [DATA_WIDTH-1:0] res_data_q;
    logic [3:0]            res_flags_q;

    logic grant_any, grant_id, accept;

    // Alternate only under contention; a lone requester always wins.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) grant_id = ~last_grant_q;
        else                          grant_id = req1_valid;
    end

    assign accept = (state_q == IDLE) && grant_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)          state_d = CALC;
            CALC:    if (cnt_q == 4'd0)   state_d = DONE;
            DONE:    if (res_ready)       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = accept && !grant_id;
        req1_ready = accept &&  grant_id;
    end

    logic        sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [7:0]  ea, eb;
    logic [22:0] frac;
    logic [24:0] quo;
    logic signed [9:0] e_calc;
    logic [DATA_WIDTH-1:0] word_d;
    logic [3:0]  flags_d;

    div24 u_div24 (.ma_i(a_q[22:0]), .mb_i(b_q[22:0]), .quo_o(quo));

    always_comb begin
        sign   = a_q[31] ^ b_q[31];
        ea     = a_q[30:23];
        eb     = b_q[30:23];
        a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
        a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        e_calc = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127
                 - (quo[24] ? 10'sd0 : 10'sd1);
        frac    = quo[24] ? quo[23:1] : quo[22:0];
        word_d  = {sign, e_calc[7:0], frac};
        flags_d = 4'b0000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            word_d  = 32'h7FC0_0000;
            flags_d = 4'b1000;
        end else if (a_inf) begin
            word_d = {sign, 8'hFF, 23'd0};
        end else if (b_zero) begin
            word_d  = {sign, 8'hFF, 23'd0};
            flags_d = 4'b0100;
        end else if (a_zero || b_inf) begin
            word_d = {sign, 31'd0};
        end else if (e_calc >= 10'sd255) begin
            word_d  = {sign, 8'hFF, 23'd0};
            flags_d = 4'b0010;
        end else if (e_calc <= 10'sd0) begin
            word_d  = {sign, 31'd0};
            flags_d = 4'b0001;
        end
    end

    // Operands stay frozen through CALC so div24 sees stable inputs for the whole window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
            res_flags_q  <= 4'd0;
        end else begin
            if (accept) begin
                a_q          <= grant_id ? req1_a : req0_a;
                b_q          <= grant_id ? req1_b : req0_b;
                id_q         <= grant_id;
                last_grant_q <= grant_id;
                cnt_q        <= CNT_INIT;
            end
            if (state_q == CALC) begin
                if (cnt_q == 4'd0) begin
                    res_valid_q <= 1'b1;
                    res_data_q  <= word_d;
                    res_id_q    <= id_q;
                    res_flags_q <= flags_d;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end
            if ((state_q == DONE) && res_ready) res_valid_q <= 1'b0;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_flags = res_flags_q;
endmodule

// File: tb/tb_fp32_div_sched.sv
// tb/tb_fp32_div_sched.sv - scoreboard bench for the shared FP32 divider scheduler
module tb_fp32_div_sched;
    localparam int DIV_LAT = 2;
    localparam int BOUND   = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        res_valid, res_ready = 1'b1, res_id;
    logic [31:0] res_data;
    logic [3:0]  res_flags;

    fp32_div_sched #(.DATA_WIDTH(32), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .res_flags(res_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        id;
        logic [3:0]  flags;
        int          acc;
    } exp_t;

    exp_t pend0[$], pend1[$], sb[$];
    logic id_log[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0, n_acc0 = 0, n_acc1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Acceptance monitor: moves the stimulus expectation into the result scoreboard.
    exp_t acc_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_ready || req1_ready)
                check("ready_onehot", 32'(req0_ready && req1_ready), 32'd0);
            if (req0_valid && req0_ready) begin
                n_acc0++;
                if (pend0.size() > 0) begin
                    acc_e = pend0.pop_front(); acc_e.acc = cyc + 1; sb.push_back(acc_e);
                end
            end
            if (req1_valid && req1_ready) begin
                n_acc1++;
                if (pend1.size() > 0) begin
                    acc_e = pend1.pop_front(); acc_e.acc = cyc + 1; sb.push_back(acc_e);
                end
            end
        end
    end

    // Result monitor: latency on the rising edge of res_valid, payload on handshake.
    logic prev_v = 1'b0;
    exp_t res_e;
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (res_valid && !prev_v) begin
                if (sb.size() == 0) check("unexpected_result", 32'd1, 32'd0);
                else check("latency", 32'(cyc - sb[0].acc), 32'(DIV_LAT));
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_handoff", res_data, 32'hxxxx_xxxx);
                end else begin
                    res_e = sb.pop_front();
                    check("res_data", res_data, res_e.data);
                    check("res_id", 32'(res_id), 32'(res_e.id));
                    check("res_flags", 32'(res_flags), 32'(res_e.flags));
                    id_log.push_back(res_id);
                end
            end
            prev_v = res_valid;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the acceptance edge.
    task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ed, input logic [3:0] ef, input bit drop);
        exp_t e;
        int   t;
        e.data = ed; e.id = (p != 0); e.flags = ef; e.acc = 0;
        if (p == 0) begin
            pend0.push_back(e); req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            pend1.push_back(e); req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(p == 0 ? req0_ready : req1_ready) && t < BOUND);
        check("accept_timeout", 32'(t >= BOUND), 32'd0);
        @(posedge clk); #1;
        if (drop) begin
            if (p == 0) req0_valid = 1'b0;
            else        req1_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() + pend0.size() + pend1.size()) != 0 && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(sb.size() + pend0.size() + pend1.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    logic [31:0] va[15], vb[15], vd[15];
    logic [3:0]  vf[15];
    logic        exp_seq[4];

    initial begin
        va[0]  = 32'h40C00000; vb[0]  = 32'h40000000; vd[0]  = 32'h40400000; vf[0]  = 4'b0000;
        va[1]  = 32'h3F800000; vb[1]  = 32'h40400000; vd[1]  = 32'h3EAAAAAA; vf[1]  = 4'b0000;
        va[2]  = 32'h3F800000; vb[2]  = 32'h00000000; vd[2]  = 32'h7F800000; vf[2]  = 4'b0100;
        va[3]  = 32'h00000000; vb[3]  = 32'h00000000; vd[3]  = 32'h7FC00000; vf[3]  = 4'b1000;
        va[4]  = 32'h7F000000; vb[4]  = 32'h00800000; vd[4]  = 32'h7F800000; vf[4]  = 4'b0010;
        va[5]  = 32'h00800000; vb[5]  = 32'h7F000000; vd[5]  = 32'h00000000; vf[5]  = 4'b0001;
        va[6]  = 32'h7FC00001; vb[6]  = 32'h3F800000; vd[6]  = 32'h7FC00000; vf[6]  = 4'b1000;
        va[7]  = 32'h7F800000; vb[7]  = 32'hFF800000; vd[7]  = 32'h7FC00000; vf[7]  = 4'b1000;
        va[8]  = 32'hFF800000; vb[8]  = 32'h40000000; vd[8]  = 32'hFF800000; vf[8]  = 4'b0000;
        va[9]  = 32'h40000000; vb[9]  = 32'hFF800000; vd[9]  = 32'h80000000; vf[9]  = 4'b0000;
        va[10] = 32'hC0C00000; vb[10] = 32'h40000000; vd[10] = 32'hC0400000; vf[10] = 4'b0000;
        va[11] = 32'hBF800000; vb[11] = 32'h00000000; vd[11] = 32'hFF800000; vf[11] = 4'b0100;
        va[12] = 32'h7F800000; vb[12] = 32'h00000000; vd[12] = 32'h7F800000; vf[12] = 4'b0000;
        va[13] = 32'h00000000; vb[13] = 32'h7F800000; vd[13] = 32'h00000000; vf[13] = 4'b0000;
        va[14] = 32'h00000000; vb[14] = 32'hC0000000; vd[14] = 32'h80000000; vf[14] = 4'b0000;
        exp_seq[0] = 1'b0; exp_seq[1] = 1'b1; exp_seq[2] = 1'b0; exp_seq[3] = 1'b1;

        @(negedge clk);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_res_flags", 32'(res_flags), 32'd0);
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) issue(i % 2, va[i], vb[i], vd[i], vf[i], 1'b1);
        wait_drain();

        // Contention: both requesters stay valid across two ops each.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        id_log.delete();
        n_acc0 = 0; n_acc1 = 0;
        fork
            begin
                issue(0, 32'h40000000, 32'h3F800000, 32'h40000000, 4'b0000, 1'b0);
                issue(0, 32'h40000000, 32'h3F800000, 32'h40000000, 4'b0000, 1'b1);
            end
            begin
                issue(1, 32'h40400000, 32'h3F800000, 32'h40400000, 4'b0000, 1'b0);
                issue(1, 32'h40400000, 32'h3F800000, 32'h40400000, 4'b0000, 1'b1);
            end
        join
        wait_drain();
        check("arb_count", 32'(id_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < id_log.size()) check("arb_order", 32'(id_log[i]), 32'(exp_seq[i]));
        check("acc0_pulses", 32'(n_acc0), 32'd2);
        check("acc1_pulses", 32'(n_acc1), 32'd2);

        // Backpressure: result held in DONE while both requesters wait.
        res_ready = 1'b0;
        issue(0, 32'h40000000, 32'h3F800000, 32'h40000000, 4'b0000, 1'b1);
        begin
            int t;
            t = 0;
            while (!res_valid && t < BOUND) begin
                @(negedge clk);
                t++;
            end
            check("bp_valid_timeout", 32'(t >= BOUND), 32'd0);
        end
        @(posedge clk); #1;
        req0_a = 32'h3F800000; req0_b = 32'h3F800000; req0_valid = 1'b1;
        req1_a = 32'h3F800000; req1_b = 32'h3F800000; req1_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 32'(res_valid), 32'd1);
            check("bp_data", res_data, 32'h40000000);
            check("bp_id", 32'(res_id), 32'd0);
            check("bp_flags", 32'(res_flags), 32'd0);
            check("bp_req0_ready", 32'(req0_ready), 32'd0);
            check("bp_req1_ready", 32'(req1_ready), 32'd0);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        res_ready = 1'b1;
        wait_drain();

        // Reset during CALC: op discarded, round-robin pointer restored.
        req0_a = 32'h40000000; req0_b = 32'h3F800000; req0_valid = 1'b1;
        begin
            int t;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!req0_ready && t < BOUND);
            check("mid_accept_timeout", 32'(t >= BOUND), 32'd0);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_req0_ready", 32'(req0_ready), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        check("post_rst_req0_ready", 32'(req0_ready), 32'd1);
        check("post_rst_req1_ready", 32'(req1_ready), 32'd0);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_no_result", 32'(res_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
